// File: rtl/bus_arbiter_pkg.sv
// Core memory-map constants and shared types for the bus arbiter and its address decoder.
package configure;

    // Address map: every window is half-open [base, top)
    localparam logic [31:0] start_base_addr    = 32'h0000_0000;
    localparam int unsigned bram_depth         = 14;
    localparam logic [31:0] bram_top_addr      = start_base_addr + 32'(2 ** (bram_depth + 2));
    localparam logic [31:0] uart_base_addr     = 32'h0010_0000;
    localparam logic [31:0] uart_top_addr      = 32'h0010_1000;
    localparam logic [31:0] clint_base_address = 32'h0200_0000;
    localparam logic [31:0] clint_top_address  = 32'h0201_0000;
    localparam logic [31:0] plic_base_addr     = 32'h0C00_0000;
    localparam logic [31:0] plic_top_addr      = 32'h1000_0000;

    // Target index doubles as the bit position in slv_valid/slv_ready and the slv_rdata lane
    typedef enum logic [1:0] {
        SLV_BRAM  = 2'd0,
        SLV_UART  = 2'd1,
        SLV_CLINT = 2'd2,
        SLV_PLIC  = 2'd3
    } slv_id_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ERR
    } arb_state_t;

    typedef enum logic {
        PORT_DATA  = 1'b0,
        PORT_INSTR = 1'b1
    } port_t;

    // Offset form keeps the lower bound free of a compare against a constant zero base
    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] top);
        return (addr - base) < (top - base);
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of the fetch port, data port and target-side signals around the bus arbiter.
// slave: the arbiter's view; master: the cores and targets that surround it.
interface bus_arbiter_if;

    logic         imem_valid;
    logic [31:0]  imem_addr;
    logic         imem_ready;
    logic [31:0]  imem_rdata;
    logic         imem_error;

    logic         dmem_valid;
    logic [31:0]  dmem_addr;
    logic [31:0]  dmem_wdata;
    logic [3:0]   dmem_wstrb;
    logic         dmem_ready;
    logic [31:0]  dmem_rdata;
    logic         dmem_error;

    logic [3:0]   slv_valid;
    logic         slv_instr;
    logic [31:0]  slv_addr;
    logic [31:0]  slv_wdata;
    logic [3:0]   slv_wstrb;
    logic [3:0]   slv_ready;
    logic [127:0] slv_rdata;

    modport slave (
        input  imem_valid, imem_addr,
        input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
        input  slv_ready, slv_rdata,
        output imem_ready, imem_rdata, imem_error,
        output dmem_ready, dmem_rdata, dmem_error,
        output slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb
    );

    modport master (
        output imem_valid, imem_addr,
        output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
        output slv_ready, slv_rdata,
        input  imem_ready, imem_rdata, imem_error,
        input  dmem_ready, dmem_rdata, dmem_error,
        input  slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb
    );

endinterface

// File: rtl/bus_decoder.sv
// Combinational address decoder: maps a bus address to a target id plus a hit flag.
module bus_decoder
    import configure::*;
(
    input  logic [31:0] i_addr,
    output logic        o_hit,
    output slv_id_t     o_id
);

    // Fixed priority so overlapping windows resolve BRAM > UART > CLINT > PLIC
    always_comb begin
        o_hit = 1'b1;
        o_id  = SLV_BRAM;
        if (in_range(i_addr, start_base_addr, bram_top_addr)) begin
            o_id = SLV_BRAM;
        end else if (in_range(i_addr, uart_base_addr, uart_top_addr)) begin
            o_id = SLV_UART;
        end else if (in_range(i_addr, clint_base_address, clint_top_address)) begin
            o_id = SLV_CLINT;
        end else if (in_range(i_addr, plic_base_addr, plic_top_addr)) begin
            o_id = SLV_PLIC;
        end else begin
            o_hit = 1'b0;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the core memory bus between fetch and data ports, one transaction at a time,
// routing each grant to BRAM/UART/CLINT/PLIC and completing unmapped or hung accesses with an error.
module bus_arbiter
    import configure::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave bus
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    arb_state_t    r_state;
    arb_state_t    w_next_state;
    port_t         r_last;
    port_t         r_port;
    port_t         w_grant;
    slv_id_t       r_sel;
    slv_id_t       w_dec_id;
    logic          w_dec_hit;
    logic          w_req;
    logic [31:0]   w_req_addr;
    logic [TW-1:0] r_timer;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_wstrb;
    logic [1:0]    w_sel_idx;
    logic          w_sel_ready;
    logic [31:0]   w_sel_rdata;
    logic          w_done;
    logic          w_err;
    logic [3:0]    w_slv_valid;

    // Round-robin pick: under contention the port that did not win last time is granted
    always_comb begin
        w_req   = bus.imem_valid | bus.dmem_valid;
        w_grant = PORT_DATA;
        if (bus.imem_valid && bus.dmem_valid) begin
            w_grant = (r_last == PORT_INSTR) ? PORT_DATA : PORT_INSTR;
        end else if (bus.imem_valid) begin
            w_grant = PORT_INSTR;
        end
        w_req_addr = (w_grant == PORT_INSTR) ? bus.imem_addr : bus.dmem_addr;
    end

    bus_decoder u_decoder (
        .i_addr (w_req_addr),
        .o_hit  (w_dec_hit),
        .o_id   (w_dec_id)
    );

    assign w_sel_idx   = r_sel;
    assign w_sel_ready = bus.slv_ready[w_sel_idx];
    assign w_sel_rdata = bus.slv_rdata[{w_sel_idx, 5'd0} +: 32];

    // Next-state and completion decode; ready from unselected targets never reaches here
    always_comb begin
        w_next_state = r_state;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_slv_valid  = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next_state = w_dec_hit ? ST_ISSUE : ST_ERR;
                end
            end
            ST_ISSUE: begin
                w_slv_valid[w_sel_idx] = 1'b1;
                if (w_sel_ready) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_sel_ready) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (r_timer == TW'(TIMEOUT)) begin
                    w_done       = 1'b1;
                    w_err        = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_ERR: begin
                w_done       = 1'b1;
                w_err        = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the granted request in IDLE; fetches never carry write strobes or data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last  <= PORT_INSTR;
            r_port  <= PORT_DATA;
            r_sel   <= SLV_BRAM;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (r_state == ST_IDLE && w_req) begin
            r_last  <= w_grant;
            r_port  <= w_grant;
            r_sel   <= w_dec_id;
            r_addr  <= w_req_addr;
            r_wdata <= (w_grant == PORT_INSTR) ? '0 : bus.dmem_wdata;
            r_wstrb <= (w_grant == PORT_INSTR) ? '0 : bus.dmem_wstrb;
        end
    end

    // Wait-cycle counter: cleared while issuing, counts every cycle spent in WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_timer <= '0;
        end else if (r_state == ST_WAIT) begin
            r_timer <= r_timer + 1'b1;
        end
    end

    // Response mux: only the granted port sees ready; error completions return zero data
    always_comb begin
        bus.imem_ready = 1'b0;
        bus.imem_error = 1'b0;
        bus.imem_rdata = '0;
        bus.dmem_ready = 1'b0;
        bus.dmem_error = 1'b0;
        bus.dmem_rdata = '0;
        if (w_done) begin
            if (r_port == PORT_INSTR) begin
                bus.imem_ready = 1'b1;
                bus.imem_error = w_err;
                bus.imem_rdata = w_err ? '0 : w_sel_rdata;
            end else begin
                bus.dmem_ready = 1'b1;
                bus.dmem_error = w_err;
                bus.dmem_rdata = w_err ? '0 : w_sel_rdata;
            end
        end
    end

    assign bus.slv_valid = w_slv_valid;
    assign bus.slv_instr = (r_port == PORT_INSTR);
    assign bus.slv_addr  = r_addr;
    assign bus.slv_wdata = r_wdata;
    assign bus.slv_wstrb = r_wstrb;

endmodule
